logic_engine_pipe: RTL and testbench
====================================

Name: logic_engine_pipe

Overview:
- Parametrised successor to the two-input gate primitives: a WIDTH-bit bitwise logic engine with a runtime operation select.
- Wrapped in a STAGES-deep valid/ready pipeline with per-stage stall and bubble collapse.
- Produces zero/parity flags and a completed-transfer counter.
- Sits between operand registers and the result bus of the course's ALU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (1..64)
- STAGES, 2, pipeline register slots between input and output (1..4)
- CNT_W, 16, width of the transfer counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  engine accepts this cycle
- in0  input  WIDTH  operand A
- in1  input  WIDTH  operand B
- op  input  3  operation select, see Behaviour
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts this cycle
- out  output  WIDTH  result
- zero  output  1  out == 0
- parity  output  1  XOR-reduction of out (1 = odd ones count)
- xfer_count  output  CNT_W  number of completed output transfers

Behaviour:
- Op encoding:
  - 0 AND, 1 OR, 2 NAND, 3 NOR
  - 4 XOR, 5 XNOR
  - 6 NOT in0 (in1 ignored)
  - 7 PASS in0
- Result is computed combinationally from in0/in1/op at acceptance and captured into stage 0. Later stages only move data; they do not recompute.
- zero and parity are computed at capture and carried with the data. They always describe the current out.
- Per-stage state: v[k] (valid) and d[k] (result, zero, parity), for k = 0..STAGES-1. Stage STAGES-1 drives out, zero, parity and out_valid.
- Ready chain (combinational):
  - rdy[STAGES] = out_ready
  - rdy[k] = !v[k] || rdy[k+1]
  - in_ready = rdy[0]
  - No combinational path from in_valid to in_ready.
- Stage k loads from stage k-1 (or from the input for k=0) when rdy[k]=1. It then takes v[k] = v[k-1] (or in_valid) and the data.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Latency: with no stall, a transfer accepted at edge E gives out_valid=1 after edge E+STAGES-1. STAGES=1 means valid in the cycle after acceptance.
- Throughput is 1 per cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, out, zero and parity hold stable. The pipeline fills to STAGES entries, then in_ready=0.
- Simultaneous output and input transfer on a full pipeline: both occur. The pipeline stays full and no data is lost.
- Ordering is strict FIFO. No reordering and no drops.
- xfer_count increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
- Reset (synchronous, active-high):
  - All v[k]=0, out_valid=0, out=0, zero=1, parity=0, xfer_count=0.
  - in_ready=1 in the first cycle after reset.
  - Reset asserted mid-stream discards all in-flight results. in_valid/out_ready seen during reset are ignored.
- Data registers need no reset except the stage driving out.
- X on in0/in1 while in_valid=0 must not propagate to out or the flags.

Decomposition:
- Shared package logic_pkg holds:
  - op encoding constants OP_AND..OP_PASS
  - typedef for the 3-bit op code
  - flag bundle typedef {zero, parity}
- Natural sub-module: logic_pipe_stage, one valid/ready register slot. Instantiated STAGES times in a generate loop.
- The logic function stays inline in the top module.

Test Plan:
- Truth table: WIDTH=8, out_ready=1, in0=8'hC3, in1=8'hA5, ops 0..7 back-to-back -> out sequence 81, E7, 7E, 18, 66, 99, 3C, C3. One per cycle, first valid after edge E+1 for STAGES=2. xfer_count=8 at end.
- Flags: AND 8'h0F & 8'hF0 -> out=00, zero=1, parity=0. XOR 8'h07 ^ 8'h00 -> out=07, zero=0, parity=1.
- Backpressure: out_ready=0 while sending 3 XOR items -> 2 accepted, then in_ready=0, out held at first result. Raise out_ready -> results drain in order and the third is accepted on the same edge as the first output transfer.
- Bubble collapse: send 1 item, hold out_ready=0 for 3 cycles -> in_ready remains 1 until both stages are valid. No data is duplicated.
- Counter wrap: CNT_W=4, 17 output transfers -> xfer_count reads 1.
- Reset mid-stream: pipeline full and stalled, assert rst for 1 cycle -> out_valid=0, out=0, zero=1, xfer_count=0, in_ready=1 on the next cycle. No stale result ever appears.

Source files
------------

// File: rtl/logic_pkg.sv
// ============================================================================
// Module   : logic_pkg
// Brief    : Operation codes and flag bundle shared by the logic engine pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_NAND = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    typedef struct packed {
        logic zero;
        logic parity;
    } flags_t;

    // Flags describing an all-zero result, used as the reset value of the output slot.
    localparam flags_t C_FLAGS_RESET = '{zero: 1'b1, parity: 1'b0};

endpackage

`default_nettype wire

// File: rtl/logic_pipe_stage.sv
// ============================================================================
// Module   : logic_pipe_stage
// Brief    : One valid/ready register slot carrying a result and its flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logic_pipe_stage
    import logic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  flags_t           up_flags,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output flags_t           dn_flags
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    flags_t           r_flags;
    logic             w_load;

    // An empty slot accepts regardless of downstream, which collapses bubbles.
    assign up_ready = !r_valid || dn_ready;
    // Data only moves with a valid beat so idle-cycle operands never reach the output.
    assign w_load   = up_ready && up_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (up_ready) begin
            r_valid <= up_valid;
        end
    end

    generate
        if (RESET_DATA) begin : g_rst_data
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data  <= '0;
                    r_flags <= C_FLAGS_RESET;
                end else if (w_load) begin
                    r_data  <= up_data;
                    r_flags <= up_flags;
                end
            end
        end else begin : g_no_rst_data
            always_ff @(posedge clk) begin
                if (w_load) begin
                    r_data  <= up_data;
                    r_flags <= up_flags;
                end
            end
        end
    endgenerate

    assign dn_valid = r_valid;
    assign dn_data  = r_data;
    assign dn_flags = r_flags;

endmodule

`default_nettype wire

// File: rtl/logic_engine_pipe.sv
// ============================================================================
// Module   : logic_engine_pipe
// Brief    : Bitwise logic engine with runtime op select, STAGES-deep
//            valid/ready pipeline, zero/parity flags and a transfer counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logic_engine_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] xfer_count
);

    logic [WIDTH-1:0] w_result;
    logic             w_valid [0:STAGES];
    logic             w_ready [0:STAGES];
    logic [WIDTH-1:0] w_data  [0:STAGES];
    flags_t           w_flags [0:STAGES];
    logic [CNT_W-1:0] r_xfer_count;

    always_comb begin
        w_result = in0;
        case (op_t'(op))
            OP_AND:  w_result = in0 & in1;
            OP_OR:   w_result = in0 | in1;
            OP_NAND: w_result = ~(in0 & in1);
            OP_NOR:  w_result = ~(in0 | in1);
            OP_XOR:  w_result = in0 ^ in1;
            OP_XNOR: w_result = ~(in0 ^ in1);
            OP_NOT:  w_result = ~in0;
            OP_PASS: w_result = in0;
            default: w_result = in0;
        endcase
    end

    // Flags are computed once at capture and travel with the result.
    assign w_valid[0]      = in_valid;
    assign w_data[0]       = w_result;
    assign w_flags[0]      = '{zero: ~|w_result, parity: ^w_result};
    assign w_ready[STAGES] = out_ready;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic_pipe_stage #(
                .WIDTH      (WIDTH),
                .RESET_DATA (k == STAGES - 1)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (w_valid[k]),
                .up_ready (w_ready[k]),
                .up_data  (w_data[k]),
                .up_flags (w_flags[k]),
                .dn_valid (w_valid[k+1]),
                .dn_ready (w_ready[k+1]),
                .dn_data  (w_data[k+1]),
                .dn_flags (w_flags[k+1])
            );
        end
    endgenerate

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[STAGES];
    assign out       = w_data[STAGES];
    assign zero      = w_flags[STAGES].zero;
    assign parity    = w_flags[STAGES].parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
        end
    end

    assign xfer_count = r_xfer_count;

endmodule

`default_nettype wire

// File: tb/tb_logic_engine_pipe.sv
// ============================================================================
// Module   : tb_logic_engine_pipe
// Brief    : Directed self-checking bench for logic_engine_pipe (WIDTH=8,
//            STAGES=2, CNT_W=4 so the counter wrap is reachable).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_logic_engine_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] xfer_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic_engine_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in0        (in0),
        .in1        (in1),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .zero       (zero),
        .parity     (parity),
        .xfer_count (xfer_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in0       = '0;
        in1       = '0;
        op        = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
        total++; if (parity !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b exp=0", parity); end
        total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_out [0:7];
        exp_out[0] = 8'h81; exp_out[1] = 8'hE7; exp_out[2] = 8'h7E; exp_out[3] = 8'h18;
        exp_out[4] = 8'h66; exp_out[5] = 8'h99; exp_out[6] = 8'h3C; exp_out[7] = 8'hC3;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            in0      = 8'hC3;
            in1      = 8'hA5;
            op       = 3'(c);
            @(negedge clk);
            if (c < 8) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL tt_in_ready c=%0d got=%b exp=1", c, in_ready); end
            end
            if (c < 2) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tt_latency c=%0d out_valid got=%b exp=0", c, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tt_valid op=%0d got=%b exp=1", c - 2, out_valid); end
                total++; if (out !== exp_out[c-2]) begin bad++; $display("FAIL tt_out op=%0d got=%h exp=%h", c - 2, out, exp_out[c-2]); end
                total++; if (zero !== (exp_out[c-2] == 8'h00)) begin bad++; $display("FAIL tt_zero op=%0d got=%b", c - 2, zero); end
                total++; if (parity !== ^exp_out[c-2]) begin bad++; $display("FAIL tt_parity op=%0d got=%b exp=%b", c - 2, parity, ^exp_out[c-2]); end
            end
            step();
        end
        in_valid = 1'b0;
        total++; if (xfer_count !== 4'd8) begin bad++; $display("FAIL tt_count got=%0d exp=8", xfer_count); end
    endtask

    task automatic test_flags();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in0 = 8'h0F; in1 = 8'hF0; op = 3'd0;
        step();
        in0 = 8'h07; in1 = 8'h00; op = 3'd4;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if ({out_valid, out, zero, parity} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL flags_and got v=%b out=%h z=%b p=%b exp v=1 out=00 z=1 p=0", out_valid, out, zero, parity); end
        step();
        @(negedge clk);
        total++; if ({out_valid, out, zero, parity} !== {1'b1, 8'h07, 1'b0, 1'b1}) begin
            bad++; $display("FAIL flags_xor got v=%b out=%h z=%b p=%b exp v=1 out=07 z=0 p=1", out_valid, out, zero, parity); end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        op = 3'd4;
        in_valid = 1'b1; in0 = 8'h11; in1 = 8'h22;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a got=%b exp=1", in_ready); end
        step();
        in0 = 8'h44; in1 = 8'h0F;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_b got=%b exp=1", in_ready); end
        step();
        in0 = 8'hF0; in1 = 8'h0F;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full c=%0d in_ready got=%b exp=0", c, in_ready); end
            total++; if ({out_valid, out, zero, parity} !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
                bad++; $display("FAIL bp_hold c=%0d got v=%b out=%h z=%b p=%b exp v=1 out=33 z=0 p=0", c, out_valid, out, zero, parity); end
            if (c == 0) step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if ({out_valid, out} !== {1'b1, 8'h4B}) begin bad++; $display("FAIL bp_second got v=%b out=%h exp v=1 out=4b", out_valid, out); end
        step();
        @(negedge clk);
        total++; if ({out_valid, out, zero, parity} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
            bad++; $display("FAIL bp_third got v=%b out=%h z=%b p=%b exp v=1 out=ff z=0 p=0", out_valid, out, zero, parity); end
        step();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
        total++; if (xfer_count !== 4'd3) begin bad++; $display("FAIL bp_count got=%0d exp=3", xfer_count); end
    endtask

    task automatic test_bubble();
        do_reset();
        op = 3'd7;
        in_valid = 1'b1; in0 = 8'h5A;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bub_in_ready c=%0d got=%b exp=1", c, in_ready); end
            total++; if (out_valid !== (c >= 2)) begin bad++; $display("FAIL bub_valid c=%0d got=%b exp=%b", c, out_valid, c >= 2); end
            if (c >= 2) begin
                total++; if (out !== 8'h5A) begin bad++; $display("FAIL bub_out c=%0d got=%h exp=5a", c, out); end
            end
            if (c == 3) begin
                in_valid = 1'b1; in0 = 8'hA5;
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bub_full got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        total++; if ({out_valid, out} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL bub_first got v=%b out=%h exp v=1 out=5a", out_valid, out); end
        step();
        @(negedge clk);
        total++; if ({out_valid, out} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL bub_second got v=%b out=%h exp v=1 out=a5", out_valid, out); end
        step();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bub_no_dup got=%b exp=0", out_valid); end
        total++; if (xfer_count !== 4'd2) begin bad++; $display("FAIL bub_count got=%0d exp=2", xfer_count); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 1'b1;
        op = 3'd1; in1 = 8'h00;
        for (int c = 0; c < 17; c++) begin
            in_valid = 1'b1;
            in0 = 8'(c);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%b exp=0", out_valid); end
        total++; if (out !== 8'h10) begin bad++; $display("FAIL wrap_last_out got=%h exp=10", out); end
        total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", xfer_count); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        op = 3'd7;
        in_valid = 1'b1; in0 = 8'h81;
        step();
        in0 = 8'h82;
        step();
        in0 = 8'h83;
        @(negedge clk);
        total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL mid_full got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready); end
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        in0 = 'x;
        in1 = 'x;
        @(negedge clk);
        total++; if ({out_valid, out, zero, parity} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL mid_reset got v=%b out=%h z=%b p=%b exp v=0 out=00 z=1 p=0", out_valid, out, zero, parity); end
        total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", xfer_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            total++; if ({out_valid, out, zero, parity} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
                bad++; $display("FAIL mid_stale c=%0d got v=%b out=%h z=%b p=%b exp v=0 out=00 z=1 p=0", c, out_valid, out, zero, parity); end
        end
        in0 = '0;
        in1 = '0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_flags();
        test_backpressure();
        test_bubble();
        test_counter_wrap();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
